// File: rtl/hwf_sha2_pad_checker_if.sv
// Padder-output stream bundle observed by the SHA-2 padding checker.
// The harness side drives it (master); the checker only listens (slave).
interface hwf_sha2_pad_checker_if #(
    parameter int WordW   = 32,
    parameter int MaxLenW = 32
);
    logic               start_i;
    logic               len_valid_i;
    logic [MaxLenW-1:0] msg_len_i;
    logic               word_fire_i;
    logic [WordW-1:0]   word_i;

    modport master (
        output start_i,
        output len_valid_i,
        output msg_len_i,
        output word_fire_i,
        output word_i
    );

    modport slave (
        input start_i,
        input len_valid_i,
        input msg_len_i,
        input word_fire_i,
        input word_i
    );
endinterface

// File: rtl/hwf_sha2_pad_checker.sv
// Sequential SHA-2 padding checker: verifies marker bit, zero fill and the
// big-endian length field of a padded word stream, with sticky/counted errors.
module hwf_sha2_pad_checker #(
    parameter int WordW   = 32,
    parameter int LenW    = 64,
    parameter int BlockW  = 512,
    parameter int MaxLenW = 32,
    parameter int ErrCntW = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    hwf_sha2_pad_checker_if.slave  bus,
    output logic                   err_o,
    output logic [2:0]             err_code_o,
    output logic [ErrCntW-1:0]     err_cnt_o,
    output logic                   done_o,
    output logic                   busy_o
);
    localparam int LOG2W = $clog2(WordW);
    localparam int LOG2B = $clog2(BlockW);
    localparam int KW    = MaxLenW - LOG2W + 2;
    localparam int LW    = LenW / WordW;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MSG  = 3'd1;
    localparam logic [2:0] ST_PAD  = 3'd2;
    localparam logic [2:0] ST_LEN  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_MARK  = 3'd1;
    localparam logic [2:0] E_ZERO  = 3'd2;
    localparam logic [2:0] E_LEN   = 3'd3;
    localparam logic [2:0] E_ORDER = 3'd4;
    localparam logic [2:0] E_UNAL  = 3'd5;

    // Marker word: bit [WordW-1-p] set, everything below it clear, message bits above ignored.
    function automatic logic f_mark_ok(input logic [WordW-1:0] word, input logic [LOG2W-1:0] p);
        logic [WordW-1:0] mask;
        logic [WordW-1:0] expv;
        mask = {WordW{1'b1}} >> p;
        expv = {1'b1, {(WordW-1){1'b0}}} >> p;
        return (word & mask) == expv;
    endfunction

    // Region the next word falls into once the length is known.
    function automatic logic [2:0] f_phase(input logic [KW-1:0] k, input logic vld,
                                           input logic [KW-1:0] i, input logic [KW-1:0] len_start);
        logic [2:0] st;
        if (!vld) begin
            st = ST_MSG;
        end else if (k < i) begin
            st = ST_MSG;
        end else if (k < len_start) begin
            st = ST_PAD;
        end else begin
            st = ST_LEN;
        end
        return st;
    endfunction

    logic [2:0]         r_state;
    logic [KW-1:0]      r_k;
    logic [MaxLenW-1:0] r_len;
    logic               r_len_vld;
    logic               r_err;
    logic [2:0]         r_code;
    logic [ErrCntW-1:0] r_cnt;
    logic               r_done;
    logic               r_busy;

    logic               w_start, w_len_valid, w_fire;
    logic [MaxLenW-1:0] w_msg_len;
    logic [WordW-1:0]   w_word;
    logic               w_active, w_cur_lv, w_take_len, w_use_vld, w_late;
    logic [KW-1:0]      w_cur_k, w_i, w_n, w_len_start, w_j, w_sh;
    logic [MaxLenW-1:0] w_use_len;
    logic [LOG2W-1:0]   w_p;
    logic [MaxLenW+1:0] w_sum;
    logic [LenW-1:0]    w_len_ext;
    logic [WordW-1:0]   w_len_word;
    logic               w_fire_ok, w_fire_idle, w_chk, w_is_mark, w_is_zero, w_is_len, w_is_last;
    logic               w_e_mark, w_e_zero, w_e_len, w_e_order, w_e_unal, w_any_err;
    logic [2:0]         w_code;
    logic [2:0]         w_state_nxt;
    logic [KW-1:0]      w_k_nxt;
    logic [MaxLenW-1:0] w_len_nxt;
    logic               w_lv_nxt;

    assign w_start     = bus.start_i;
    assign w_len_valid = bus.len_valid_i;
    assign w_msg_len   = bus.msg_len_i;
    assign w_fire      = bus.word_fire_i;
    assign w_word      = bus.word_i;

    // A start in the same cycle resets the view of the message before anything else is applied.
    assign w_active   = w_start | (r_state == ST_MSG) | (r_state == ST_PAD) | (r_state == ST_LEN);
    assign w_cur_k    = w_start ? {KW{1'b0}} : r_k;
    assign w_cur_lv   = w_start ? 1'b0 : r_len_vld;
    assign w_take_len = w_len_valid & w_active & ~w_cur_lv;
    assign w_use_len  = w_take_len ? w_msg_len : r_len;
    assign w_use_vld  = w_cur_lv | w_take_len;

    assign w_i         = KW'(w_use_len[MaxLenW-1:LOG2W]);
    assign w_p         = w_use_len[LOG2W-1:0];
    assign w_sum       = (MaxLenW+2)'(w_use_len) + (MaxLenW+2)'(LenW + BlockW);
    assign w_n         = KW'(w_sum >> LOG2B) << (LOG2B - LOG2W);
    assign w_len_start = w_n - KW'(LW);
    assign w_late      = w_take_len & (w_i < w_cur_k);

    assign w_fire_ok   = w_fire & w_active & ~w_late;
    assign w_fire_idle = w_fire & ~w_active;
    assign w_chk       = w_fire_ok & w_use_vld;
    assign w_is_mark   = w_cur_k == w_i;
    assign w_is_zero   = (w_cur_k > w_i) & (w_cur_k < w_len_start);
    assign w_is_len    = (w_cur_k >= w_len_start) & (w_cur_k < w_n);
    assign w_is_last   = w_chk & (w_cur_k == (w_n - KW'(1)));

    assign w_j        = w_cur_k - w_len_start;
    assign w_sh       = KW'(LW - 1) - w_j;
    assign w_len_ext  = LenW'(w_use_len);
    assign w_len_word = WordW'(w_len_ext >> (w_sh << LOG2W));

    assign w_e_mark  = w_chk & w_is_mark & ~f_mark_ok(w_word, w_p);
    assign w_e_zero  = w_chk & w_is_zero & (w_word != {WordW{1'b0}});
    assign w_e_len   = w_chk & w_is_len & (w_word != w_len_word);
    assign w_e_order = w_late | w_fire_idle | (w_len_valid & w_active & w_cur_lv);
    assign w_e_unal  = w_take_len & (w_msg_len[2:0] != 3'd0);
    assign w_any_err = w_e_mark | w_e_zero | w_e_len | w_e_order | w_e_unal;

    // Lowest-numbered error code wins when several fire together.
    always_comb begin
        w_code = E_NONE;
        if (w_e_mark) begin
            w_code = E_MARK;
        end else if (w_e_zero) begin
            w_code = E_ZERO;
        end else if (w_e_len) begin
            w_code = E_LEN;
        end else if (w_e_order) begin
            w_code = E_ORDER;
        end else if (w_e_unal) begin
            w_code = E_UNAL;
        end else begin
            w_code = E_NONE;
        end
    end

    // Next state, word index and stored length.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_len_nxt   = r_len;
        w_lv_nxt    = r_len_vld;
        if (w_late) begin
            w_state_nxt = ST_IDLE;
            w_k_nxt     = {KW{1'b0}};
            w_lv_nxt    = 1'b0;
        end else if (w_active) begin
            w_lv_nxt  = w_use_vld;
            w_len_nxt = w_take_len ? w_msg_len : (w_start ? {MaxLenW{1'b0}} : r_len);
            if (w_is_last) begin
                w_state_nxt = ST_DONE;
                w_k_nxt     = {KW{1'b0}};
            end else begin
                w_k_nxt     = w_fire_ok ? (w_cur_k + KW'(1)) : w_cur_k;
                w_state_nxt = f_phase(w_k_nxt, w_use_vld, w_i, w_len_start);
            end
        end else begin
            w_state_nxt = ST_IDLE;
            w_k_nxt     = {KW{1'b0}};
            w_lv_nxt    = 1'b0;
        end
    end

    // Message-tracking registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_k       <= {KW{1'b0}};
            r_len     <= {MaxLenW{1'b0}};
            r_len_vld <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_len     <= w_len_nxt;
            r_len_vld <= w_lv_nxt;
            r_done    <= w_is_last;
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    // Sticky error flag, last error code and saturating error count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err  <= 1'b0;
            r_code <= E_NONE;
            r_cnt  <= {ErrCntW{1'b0}};
        end else if (w_any_err) begin
            r_err  <= 1'b1;
            r_code <= w_code;
            r_cnt  <= (r_cnt == {ErrCntW{1'b1}}) ? r_cnt : (r_cnt + ErrCntW'(1));
        end else begin
            r_err  <= r_err;
            r_code <= r_code;
            r_cnt  <= r_cnt;
        end
    end

    assign err_o      = r_err;
    assign err_code_o = r_code;
    assign err_cnt_o  = r_cnt;
    assign done_o     = r_done;
    assign busy_o     = r_busy;
endmodule

// File: tb/tb_hwf_sha2_pad_checker.sv
// Directed bench for hwf_sha2_pad_checker (SHA-256 widths) with hand-computed padding vectors.
module tb_hwf_sha2_pad_checker;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       err_o;
    logic [2:0] err_code_o;
    logic [7:0] err_cnt_o;
    logic       done_o;
    logic       busy_o;

    int n_checks = 0;
    int n_errors = 0;
    int dones;
    logic [31:0] tb_words [0:31];

    hwf_sha2_pad_checker_if #(.WordW(32), .MaxLenW(32)) u_if ();

    hwf_sha2_pad_checker #(
        .WordW(32), .LenW(64), .BlockW(512), .MaxLenW(32), .ErrCntW(8)
    ) u_dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .bus        (u_if.slave),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .err_cnt_o  (err_cnt_o),
        .done_o     (done_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start();
        u_if.start_i = 1'b1;
        tick();
        u_if.start_i = 1'b0;
    endtask

    task automatic do_len(input logic [31:0] len);
        u_if.len_valid_i = 1'b1;
        u_if.msg_len_i   = len;
        tick();
        u_if.len_valid_i = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        u_if.word_fire_i = 1'b1;
        u_if.word_i      = w;
        tick();
        u_if.word_fire_i = 1'b0;
        u_if.word_i      = 32'h0;
    endtask

    task automatic clear_words();
        for (int k = 0; k < 32; k++) tb_words[k] = 32'h0;
    endtask

    // Fires tb_words[first..last-1], accumulating observed done pulses.
    task automatic run_words(input int first, input int last);
        for (int k = first; k < last; k++) begin
            send(tb_words[k]);
            dones += int'(done_o);
        end
    endtask

    initial begin
        rst_ni           = 1'b0;
        u_if.start_i     = 1'b0;
        u_if.len_valid_i = 1'b0;
        u_if.msg_len_i   = 32'h0;
        u_if.word_fire_i = 1'b0;
        u_if.word_i      = 32'h0;
        tick();
        tick();
        chk("rst_err", err_o, 0);
        chk("rst_code", err_code_o, 0);
        chk("rst_cnt", err_cnt_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_ni = 1'b1;
        tick();

        // L=0: single block, marker in word 0
        clear_words(); tb_words[0] = 32'h8000_0000;
        do_start();
        chk("l0_busy", busy_o, 1);
        do_len(32'd0);
        dones = 0; run_words(0, 16);
        chk("l0_done_last", done_o, 1);
        chk("l0_dones", dones, 1);
        chk("l0_err", err_o, 0);
        tick();
        chk("l0_idle_busy", busy_o, 0);
        chk("l0_idle_done", done_o, 0);

        // L=24 "abc"
        clear_words(); tb_words[0] = 32'h6162_6380; tb_words[15] = 32'h0000_0018;
        do_start(); do_len(32'd24);
        dones = 0; run_words(0, 16); tick();
        chk("l24_dones", dones, 1);
        chk("l24_err", err_o, 0);

        // L=448: marker at k=14 forces a second block
        clear_words(); tb_words[14] = 32'h8000_0000; tb_words[31] = 32'h0000_01C0;
        do_start(); do_len(32'd448);
        dones = 0; run_words(0, 31);
        chk("l448_no_early_done", dones, 0);
        run_words(31, 32); tick();
        chk("l448_dones", dones, 1);
        chk("l448_err", err_o, 0);

        // start + len_valid + fire together, k == i == 0, L=8
        clear_words(); tb_words[15] = 32'h0000_0008;
        u_if.start_i = 1'b1; u_if.len_valid_i = 1'b1; u_if.msg_len_i = 32'd8;
        u_if.word_fire_i = 1'b1; u_if.word_i = 32'hAB80_0000;
        tick();
        u_if.start_i = 1'b0; u_if.len_valid_i = 1'b0; u_if.word_fire_i = 1'b0;
        dones = 0; run_words(1, 16); tick();
        chk("same_cyc_dones", dones, 1);
        chk("same_cyc_err", err_o, 0);

        // MARK error, stream keeps counting
        clear_words(); tb_words[15] = 32'h0000_0018;
        do_start(); do_len(32'd24);
        send(32'h6162_6300);
        chk("mark_err", err_o, 1);
        chk("mark_code", err_code_o, 1);
        chk("mark_cnt", err_cnt_o, 1);
        dones = 0; run_words(1, 16); tick();
        chk("mark_dones", dones, 1);
        chk("mark_cnt_after", err_cnt_o, 1);

        // UNALIGNED length L=3, still checked
        clear_words(); tb_words[0] = 32'h1000_0000; tb_words[15] = 32'h0000_0003;
        do_start(); do_len(32'd3);
        chk("unal_code", err_code_o, 5);
        chk("unal_cnt", err_cnt_o, 2);
        dones = 0; run_words(0, 16); tick();
        chk("unal_dones", dones, 1);
        chk("unal_cnt_after", err_cnt_o, 2);

        // ZERO error in fill word 5
        clear_words(); tb_words[0] = 32'h8000_0000;
        do_start(); do_len(32'd0);
        dones = 0; run_words(0, 5);
        send(32'h0000_0001);
        chk("zero_code", err_code_o, 2);
        chk("zero_cnt", err_cnt_o, 3);
        run_words(6, 16); tick();
        chk("zero_dones", dones, 1);

        // LEN error on the final word
        clear_words(); tb_words[0] = 32'h6162_6380;
        do_start(); do_len(32'd24);
        dones = 0; run_words(0, 15);
        send(32'h0000_0019);
        chk("len_code", err_code_o, 3);
        chk("len_cnt", err_cnt_o, 4);
        chk("len_done", done_o, 1);

        // ORDER: length arrives after marker word already fired
        tick();
        do_start();
        send(32'h0); send(32'h0);
        do_len(32'd32);
        chk("late_code", err_code_o, 4);
        chk("late_cnt", err_cnt_o, 5);
        chk("late_busy", busy_o, 0);

        // ORDER: second length ignored, first kept
        clear_words(); tb_words[0] = 32'h6162_6380; tb_words[15] = 32'h0000_0018;
        do_start(); do_len(32'd24); do_len(32'd32);
        chk("dup_code", err_code_o, 4);
        chk("dup_cnt", err_cnt_o, 6);
        chk("dup_busy", busy_o, 1);
        dones = 0; run_words(0, 16); tick();
        chk("dup_dones", dones, 1);
        chk("dup_cnt_after", err_cnt_o, 6);

        // Silent restart mid-message
        clear_words(); tb_words[0] = 32'h8000_0000;
        do_start(); do_len(32'd24); send(32'h6162_6380); send(32'h0);
        do_start(); do_len(32'd0);
        dones = 0; run_words(0, 16); tick();
        chk("restart_dones", dones, 1);
        chk("restart_cnt", err_cnt_o, 6);

        // 300 fires in IDLE saturate the counter
        u_if.word_fire_i = 1'b1;
        for (int n = 0; n < 300; n++) tick();
        u_if.word_fire_i = 1'b0;
        tick();
        chk("sat_cnt", err_cnt_o, 255);
        chk("sat_code", err_code_o, 4);
        chk("sat_busy", busy_o, 0);

        // Asynchronous reset mid-message
        do_start(); do_len(32'd0); send(32'h8000_0000); send(32'h0);
        chk("pre_rst_busy", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("arst_err", err_o, 0);
        chk("arst_code", err_code_o, 0);
        chk("arst_cnt", err_cnt_o, 0);
        chk("arst_done", done_o, 0);
        chk("arst_busy", busy_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/hwf_sha2_pad_checker.md
# hwf_sha2_pad_checker

Parametrised SHA-2 padding checker: a sequential successor to single-cycle padding assertions, for fuzzing harnesses. It watches the padded word stream leaving a SHA-2 padder and checks every padding word against a golden model: the 1-bit marker, zero fill and big-endian length field. Widths are generic, so SHA-256 (32/64/512) and SHA-512 (64/128/1024) are both covered. Error outputs are sticky and counted, so a harness can assert on them or export them as coverage.

## Interface
- WordW, 32: padder output word width in bits (32 or 64).
- LenW, 64: length-field width in bits (64 or 128); multiple of WordW.
- BlockW, 512: block size in bits (512 or 1024); multiple of WordW.
- MaxLenW, 32: supported message-length width; lengths are zero-extended to LenW.
- ErrCntW, 8: error counter width.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  pulse: new message; clears the word counter and the stored length.
- len_valid_i  in  1  pulse: msg_len_i is valid.
- msg_len_i  in  MaxLenW  message length in bits.
- word_fire_i  in  1  padder output handshake (valid & ready); one word transferred.
- word_i  in  WordW  padder output word.
- err_o  out  1  sticky: any error since reset.
- err_code_o  out  3  code of the most recent error: 0 none, 1 MARK, 2 ZERO, 3 LEN, 4 ORDER, 5 UNALIGNED.
- err_cnt_o  out  ErrCntW  saturating error count.
- done_o  out  1  pulse: last padded word accepted.
- busy_o  out  1  a message is in flight (state is not IDLE).

## Operation
- States:
  - IDLE: until start_i, go to MSG.
  - MSG: word_fire_i increments word index k.
  - PAD: k ≥ marker index i, and k < N−LenW/WordW.
  - LEN: last LenW/WordW words.
  - DONE: one cycle, then IDLE.
- Derived values, latched at len_valid_i:
  - L = msg_len_i.
  - i = L / WordW.
  - p = L % WordW.
  - N = ceil((L+1+LenW)/BlockW)·BlockW/WordW.
- MSG words (k < i) are not checked.
- Word k == i (MARK check):
  - bit [WordW−1−p] must be 1.
  - bits [WordW−2−p:0] must be 0.
  - bits above p are message data and are don't-care.
- Words i < k < N−LenW/WordW (ZERO check): must be all-zero.
- LEN words, j = 0 .. LenW/WordW−1:
  - word_i must equal the zero-extended L, slice [LenW−1−j·WordW −: WordW] (big-endian).
- The fire with k == N−1 moves the FSM to DONE; done_o pulses.
- Error cases:
  - len_valid_i when L % 8 ≠ 0: UNALIGNED. The length is still latched and checking proceeds.
  - len_valid_i arriving after word index i has already fired: ORDER. Return to IDLE.
  - word_fire_i in IDLE (no start_i in the same cycle): ORDER.
  - A second len_valid_i in one message: ORDER. Keep the first length.
- Each error cycle:
  - err_o is set.
  - err_code_o is overwritten.
  - err_cnt_o increments, saturating at all-ones.
  - If several errors occur in one cycle: count 1; the lowest-numbered nonzero code wins.
- A checking error does not abort the stream; counting continues to N.

## Timing
- Reset values: err_o=0, err_code_o=0, err_cnt_o=0, done_o=0, busy_o=0, state IDLE, k=0.
- All outputs are registered.
  - Error outputs update the cycle after the offending word_fire_i or len_valid_i.
  - done_o is high for exactly one cycle, the cycle after the final fire.
- Simultaneous start_i and word_fire_i: start wins; the word is counted as k=0 of the new message.
- start_i in MSG/PAD/LEN: abort silently and restart. No error; sticky errors are kept.
- len_valid_i and word_fire_i in the same cycle with k == i: the new length applies to that word, with no ORDER error.
- Reset mid-message: all state clears immediately (asynchronously).
- k width: MaxLenW − log2(WordW) + 2 bits; no wrap is possible within supported lengths.

## Test plan
- WordW=32, L=0: word0=0x8000_0000, words 1–15 zero → err_o=0; done_o pulses after the 16th fire.
- L=24, word0=0x6162_6380, words 1–14 zero, word15=0x0000_0018 → no error; done_o once.
- L=448: marker at k=14 = 0x8000_0000, N=32, word31=0x0000_01C0, all others zero → no error.
- L=24 with word0=0x6162_6300 → err_o=1, err_code_o=1, err_cnt_o=1 the next cycle; counting continues to done_o.
- L=32 with len_valid_i after word1 fires → err_code_o=4; busy_o=0.
- Inject 300 errors with ErrCntW=8 → err_cnt_o saturates at 255. Then assert rst_ni mid-message → all outputs read 0.
